// File: rtl/logic_unit_pkg.sv
// Shared constants for the registered logic unit: op encoding and counter width.
package logic_unit_pkg;

  localparam int OP_W      = 2;
  localparam int TXN_CNT_W = 16;

  localparam logic [OP_W-1:0] OP_AND  = 2'd0;
  localparam logic [OP_W-1:0] OP_OR   = 2'd1;
  localparam logic [OP_W-1:0] OP_XOR  = 2'd2;
  localparam logic [OP_W-1:0] OP_NAND = 2'd3;

endpackage

// File: rtl/logic_reduce.sv
// Combinational bitwise reduction of NUM_IN lanes under a selectable op,
// plus an all-zero flag on the result.
module logic_reduce
  import logic_unit_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 2
) (
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [OP_W-1:0]         in_op,
  output logic [WIDTH-1:0]        result,
  output logic                    zero
);

  logic [WIDTH-1:0] and_acc;
  logic [WIDTH-1:0] or_acc;
  logic [WIDTH-1:0] xor_acc;

  always_comb begin
    and_acc = '1;
    or_acc  = '0;
    xor_acc = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      and_acc = and_acc & in_data[i*WIDTH +: WIDTH];
      or_acc  = or_acc  | in_data[i*WIDTH +: WIDTH];
      xor_acc = xor_acc ^ in_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    result = '0;
    case (in_op)
      OP_AND:  result = and_acc;
      OP_OR:   result = or_acc;
      OP_XOR:  result = xor_acc;
      OP_NAND: result = ~and_acc;
      default: result = '0;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// One-stage registered logic unit with valid/ready on both sides.
// Optional accept counter enabled by LOGIC_UNIT_PIPE_TXN_CNT_EN.
//
// state | meaning
// EMPTY | valid_q=0, no result held
// FULL  | valid_q=1, out_data/out_zero hold a result
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [OP_W-1:0]         in_op,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_zero,
  output logic [TXN_CNT_W-1:0]    txn_count
);

  logic [WIDTH-1:0] res;
  logic             res_zero;
  logic             accept;

  logic             valid_d, valid_q;
  logic [WIDTH-1:0] data_d,  data_q;
  logic             zero_d,  zero_q;

  logic_reduce #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN)
  ) u_reduce (
    .in_data (in_data),
    .in_op   (in_op),
    .result  (res),
    .zero    (res_zero)
  );

  // A draining result frees the slot in the same cycle, so no bubble.
  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    zero_d  = zero_q;
    if (accept) begin
      valid_d = 1'b1;
      data_d  = res;
      zero_d  = res_zero;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      zero_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      zero_q  <= zero_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_zero  = zero_q;

`ifdef LOGIC_UNIT_PIPE_TXN_CNT_EN
  logic [TXN_CNT_W-1:0] cnt_d, cnt_q;

  // Saturates at all-ones rather than wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (accept && (cnt_q != '1)) begin
      cnt_d = cnt_q + TXN_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign txn_count = cnt_q;
`else
  assign txn_count = '0;
`endif

endmodule
